// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one AXI master port between the D-cache (requester 0) and the
// I-cache (requester 1). Each request moves a full cache line as one INCR
// burst. Only one transaction is outstanding at a time. Ties are broken
// round-robin.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req_valid[1:0]      line request per requester (bit0 D, bit1 I)
//   req_store[1:0]      1 = write-back, 0 = fill
//   req_addr            requester n address at [n*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wline           requester n write-back line at [n*LINE +: LINE]
//   resp_valid[1:0]     one-cycle completion pulse to the granted requester
//   resp_rline          fill data, held until the next fill starts
//   busy                high whenever a transaction is in progress
//   m_axi_ar*/r*        AXI read address / read data channels
//   m_axi_aw*/w*/b*     AXI write address / write data / write response
module mem_bus_arbiter #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BEATS      = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [1:0]                       req_valid,
    input  logic [1:0]                       req_store,
    input  logic [2*ADDR_WIDTH-1:0]          req_addr,
    input  logic [2*DATA_WIDTH*BEATS-1:0]    req_wline,
    output logic [1:0]                       resp_valid,
    output logic [DATA_WIDTH*BEATS-1:0]      resp_rline,
    output logic                             busy,
    output logic [ID_WIDTH-1:0]              m_axi_arid,
    output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
    output logic [7:0]                       m_axi_arlen,
    output logic [2:0]                       m_axi_arsize,
    output logic [1:0]                       m_axi_arburst,
    output logic                             m_axi_arvalid,
    input  logic                             m_axi_arready,
    input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
    input  logic                             m_axi_rlast,
    input  logic                             m_axi_rvalid,
    output logic                             m_axi_rready,
    output logic [ID_WIDTH-1:0]              m_axi_awid,
    output logic [ADDR_WIDTH-1:0]            m_axi_awaddr,
    output logic [7:0]                       m_axi_awlen,
    output logic [2:0]                       m_axi_awsize,
    output logic [1:0]                       m_axi_awburst,
    output logic                             m_axi_awvalid,
    input  logic                             m_axi_awready,
    output logic [DATA_WIDTH-1:0]            m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]          m_axi_wstrb,
    output logic                             m_axi_wlast,
    output logic                             m_axi_wvalid,
    input  logic                             m_axi_wready,
    input  logic                             m_axi_bvalid,
    output logic                             m_axi_bready
);

    localparam int LINE  = DATA_WIDTH * BEATS;
    localparam int OFF   = $clog2(LINE / 8);
    localparam int SIZE  = $clog2(DATA_WIDTH / 8);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, DONE} state_t;

    state_t                  state;
    state_t                  next_state;
    logic                    grant;
    logic                    last_grant;
    logic                    pick;
    logic                    last_beat;
    logic [CNT_W-1:0]        count;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [LINE-1:0]         wline;

    // On a tie the requester that was not served last wins.
    assign pick      = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    assign sel_addr  = req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
    assign last_beat = (count == CNT_W'(BEATS - 1));

    // Address-channel fields are constant per transaction; the valid
    // signals from the FSM qualify them.
    assign m_axi_arid    = ID_WIDTH'(grant);
    assign m_axi_araddr  = addr;
    assign m_axi_arlen   = 8'(BEATS - 1);
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = 2'b01;
    assign m_axi_awid    = ID_WIDTH'(grant);
    assign m_axi_awaddr  = addr;
    assign m_axi_awlen   = 8'(BEATS - 1);
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_wdata   = wline[count*DATA_WIDTH +: DATA_WIDTH];
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = last_beat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        busy          = 1'b1;
        resp_valid    = 2'b00;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (|req_valid) begin
                    next_state = req_store[pick] ? AW : AR;
                end
            end
            AR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) next_state = R;
            end
            R: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid && m_axi_rlast) next_state = DONE;
            end
            AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) next_state = W;
            end
            W: begin
                m_axi_wvalid = 1'b1;
                if (m_axi_wready && last_beat) next_state = B;
            end
            B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) next_state = DONE;
            end
            DONE: begin
                resp_valid[grant] = 1'b1;
                next_state        = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            count      <= '0;
            resp_rline <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant      <= pick;
                        last_grant <= pick;
                        count      <= '0;
                        // Cleared on the way into AR so an early rlast
                        // leaves the missing words at zero.
                        if (!req_store[pick]) resp_rline <= '0;
                    end
                end
                AR: if (m_axi_arready) count <= '0;
                R: begin
                    if (m_axi_rvalid) begin
                        // Count saturates, so surplus beats overwrite
                        // the last word.
                        resp_rline[count*DATA_WIDTH +: DATA_WIDTH] <= m_axi_rdata;
                        if (!last_beat) count <= count + 1'b1;
                    end
                end
                AW: if (m_axi_awready) count <= '0;
                W: if (m_axi_wready && !last_beat) count <= count + 1'b1;
                default: ;
            endcase
        end
    end

    // Request payload captured at grant; needs no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && |req_valid) begin
            addr  <= {sel_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
            wline <= req_wline[pick*LINE +: LINE];
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam int IDW  = 13;
    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int NB   = 8;
    localparam int LINE = DW * NB;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req_valid, req_store;
    logic [2*AW-1:0]   req_addr;
    logic [2*LINE-1:0] req_wline;
    logic [1:0]        resp_valid;
    logic [LINE-1:0]   resp_rline;
    logic              busy;
    logic [IDW-1:0]    arid, awid;
    logic [AW-1:0]     araddr, awaddr;
    logic [7:0]        arlen, awlen;
    logic [2:0]        arsize, awsize;
    logic [1:0]        arburst, awburst;
    logic              arvalid, arready, rlast, rvalid, rready;
    logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [DW-1:0]     rdata, wdata;
    logic [DW/8-1:0]   wstrb;

    mem_bus_arbiter #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(NB)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_store(req_store), .req_addr(req_addr), .req_wline(req_wline),
        .resp_valid(resp_valid), .resp_rline(resp_rline), .busy(busy),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rv;
        logic [1:0]  st;
        logic [63:0] a0;
        logic [63:0] a1;
        int          rl;    // index of the beat carrying rlast
        int          mode;  // 0 no waits, 1 alternate waits, 2 long addr stall, 3 random
        bit          hold;  // keep req_valid asserted after the grant
        logic [63:0] base;
        int          eg;    // expected grant
        logic [63:0] ea;    // expected line-aligned address
    } vec_t;

    vec_t            tbl[8];
    vec_t            rnd;
    int              checks = 0;
    int              errors = 0;
    logic            mlast;
    logic [LINE-1:0] mline;

    task automatic chk(input string nm, input logic [LINE-1:0] got, input logic [LINE-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s got timeout exp handshake", nm);
    endtask

    // Issues one request, plays an AXI slave for it and checks every cycle.
    task automatic run_txn(input vec_t v);
        logic [LINE-1:0] eline, ewl;
        logic fill;
        int n, k, stall;
        bit done, give;
        fill = !v.st[v.eg];
        req_store = v.st;
        req_addr  = {v.a1, v.a0};
        for (int i = 0; i < NB; i++) ewl[i*DW +: DW] = v.base ^ (64'h11 * (i + 1));
        req_wline = {~ewl, ewl};
        if (v.eg == 1) ewl = ~ewl;
        req_valid = v.rv;
        n = 0;
        @(negedge clk);
        while (!busy && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("grant_busy", busy, 1);
        if (!busy) begin
            req_valid = 2'b00;
            return;
        end
        if (!v.hold) req_valid = 2'b00;

        stall = (v.mode == 2) ? 5 : (v.mode == 3) ? $urandom_range(0, 3) : 0;
        for (int c = 0; c <= stall; c++) begin
            chk("addr_valid", fill ? arvalid : awvalid, 1);
            chk("other_valid", fill ? awvalid : arvalid, 0);
            chk("data_early", fill ? rready : wvalid, 0);
            chk("addr", fill ? araddr : awaddr, v.ea);
            chk("busy_addr", busy, 1);
            if (c == stall) begin
                chk("id", fill ? arid : awid, v.eg);
                chk("len", fill ? arlen : awlen, NB - 1);
                chk("size", fill ? arsize : awsize, 3);
                chk("burst", fill ? arburst : awburst, 1);
                if (fill) arready = 1'b1;
                else awready = 1'b1;
            end
            @(negedge clk);
            arready = 1'b0;
            awready = 1'b0;
        end

        if (fill) begin
            eline = '0;
            k = 0; n = 0; done = 0;
            while (!done && n < 100) begin
                chk("rready", rready, 1);
                give = (v.mode == 1) ? (n % 2 == 1) : (v.mode == 3) ? ($urandom_range(0, 1) == 1) : 1'b1;
                rvalid = give;
                rdata  = v.base + k;
                rlast  = give && (k == v.rl);
                if (give) begin
                    eline[((k < NB) ? k : NB - 1)*DW +: DW] = v.base + k;
                    done = (k == v.rl);
                    k++;
                end
                @(negedge clk);
                n++;
            end
            rvalid = 1'b0;
            rlast  = 1'b0;
            if (!done) fail("r_timeout");
        end else begin
            k = 0; n = 0;
            while (k < NB && n < 100) begin
                chk("wvalid", wvalid, 1);
                chk("wdata", wdata, ewl[k*DW +: DW]);
                chk("wlast", wlast, (k == NB - 1));
                chk("wstrb", wstrb, 8'hff);
                chk("aw_once", awvalid, 0);
                give = (v.mode == 1) ? (n % 2 == 1) : (v.mode == 3) ? ($urandom_range(0, 1) == 1) : 1'b1;
                wready = give;
                @(negedge clk);
                wready = 1'b0;
                if (give) k++;
                n++;
            end
            if (k < NB) fail("w_timeout");
            stall = (v.mode == 3) ? $urandom_range(0, 3) : (v.mode == 1) ? 2 : 0;
            for (int c = 0; c <= stall; c++) begin
                chk("bready", bready, 1);
                chk("wvalid_b", wvalid, 0);
                if (c == stall) bvalid = 1'b1;
                @(negedge clk);
                bvalid = 1'b0;
            end
        end

        chk("resp_valid", resp_valid, (v.eg == 1) ? 2'b10 : 2'b01);
        if (fill) mline = eline;
        chk("resp_rline", resp_rline, mline);
        @(negedge clk);
        chk("resp_pulse", resp_valid, 0);
        chk("idle_busy", busy, 0);
        chk("rline_hold", resp_rline, mline);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid = 2'b00; req_store = 2'b00; req_addr = '0; req_wline = '0;
        arready = 0; rvalid = 0; rlast = 0; rdata = '0; awready = 0; wready = 0; bvalid = 0;

        tbl[0] = '{2'b11, 2'b00, 64'h0000_0000_8000_1038, 64'h0000_0000_4000_0010, 7, 0, 1'b1, 64'h0,   0, 64'h0000_0000_8000_1000};
        tbl[1] = '{2'b11, 2'b00, 64'h0000_0000_8000_1038, 64'h0000_0000_4000_0010, 7, 0, 1'b1, 64'h100, 1, 64'h0000_0000_4000_0000};
        tbl[2] = '{2'b11, 2'b00, 64'h0000_0000_0000_207f, 64'h0000_0000_0000_207f, 7, 0, 1'b1, 64'h200, 0, 64'h0000_0000_0000_2040};
        tbl[3] = '{2'b01, 2'b01, 64'hffff_ffff_ffff_ffc1, 64'h0,                   7, 1, 1'b0, 64'h0,   0, 64'hffff_ffff_ffff_ffc0};
        tbl[4] = '{2'b10, 2'b00, 64'h0,                   64'hdead_beef_0000_0123, 7, 2, 1'b0, 64'h400, 1, 64'hdead_beef_0000_0100};
        tbl[5] = '{2'b01, 2'b00, 64'h0000_0000_0000_0040, 64'h0,                   3, 0, 1'b0, 64'h500, 0, 64'h0000_0000_0000_0040};
        tbl[6] = '{2'b11, 2'b10, 64'h0000_0000_0000_3000, 64'h0123_4567_89ab_cdef, 7, 1, 1'b0, 64'h600, 1, 64'h0123_4567_89ab_cdc0};
        tbl[7] = '{2'b11, 2'b11, 64'h0000_0000_0000_1fff, 64'h0000_0000_0000_9000, 7, 2, 1'b0, 64'h700, 0, 64'h0000_0000_0000_1fc0};

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rline", resp_rline, 0);
        reset = 1'b0;
        mlast = 1'b1;
        mline = '0;

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i]);
            mlast = tbl[i].eg[0];
        end

        // Reset in the middle of a fill burst.
        req_store = 2'b00;
        req_addr  = {64'h0, 64'h0000_0000_0000_5000};
        req_valid = 2'b01;
        @(negedge clk);
        chk("mid_busy", busy, 1);
        req_valid = 2'b00;
        chk("mid_arvalid", arvalid, 1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mid_rready", rready, 1);
            rvalid = 1'b1; rdata = 64'ha0 + i; rlast = 1'b0;
            @(negedge clk);
        end
        rvalid = 1'b1; rdata = 64'ha3;
        #2 reset = 1'b1;
        #1;
        chk("abort_arvalid", arvalid, 0);
        chk("abort_rready", rready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_resp_valid", resp_valid, 0);
        chk("abort_rline", resp_rline, 0);
        @(negedge clk);
        rvalid = 1'b0;
        chk("abort_resp_valid2", resp_valid, 0);
        reset = 1'b0;
        mlast = 1'b1;
        mline = '0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_resp", resp_valid, 0);
            chk("post_rst_busy", busy, 0);
        end
        rnd = '{2'b11, 2'b00, 64'h0000_0000_0000_5008, 64'h0000_0000_0000_6000, 7, 0, 1'b0, 64'h900, 0, 64'h0000_0000_0000_5000};
        run_txn(rnd);
        mlast = 1'b0;

        // Random traffic against the round-robin model.
        for (int t = 0; t < 40; t++) begin
            rnd.rv   = 2'($urandom_range(1, 3));
            rnd.st   = 2'($urandom_range(0, 3));
            rnd.a0   = {$urandom, $urandom};
            rnd.a1   = {$urandom, $urandom};
            rnd.rl   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : NB - 1;
            rnd.mode = 3;
            rnd.hold = 1'b0;
            rnd.base = {$urandom, $urandom};
            if (rnd.rv == 2'b11) rnd.eg = mlast ? 0 : 1;
            else rnd.eg = rnd.rv[1] ? 1 : 0;
            mlast  = rnd.eg[0];
            rnd.ea = ((rnd.eg == 1 ? rnd.a1 : rnd.a0) / 64) * 64;
            run_txn(rnd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
